packetizer: RTL and testbench
=============================

# packetizer

Transmit-side framer for the stream sequence protocol. Accepts one whole message per handshake (stream id, payload up to 37 bytes, byte count), assigns the next per-stream sequence number, and serialises it as 32-bit words with a valid/ready/last handshake. The word format is exactly the one the parser consumes: a header word, a sequence word, then payload words. It sits upstream of the parser, or drives the link the parser listens on.

## Interface
- NUM_STREAMS, 16: number of per-stream sequence counters; the stream id must be below this.
- MAX_PAYLOAD_BYTES, 37: maximum payload; 37 bytes gives a maximum wire length of 45.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- msgIn  in  [0:295]  payload; byte k occupies bits [8k:8k+7]; bytes at or beyond msgIn_len are ignored.
- msgIn_stream  in  16  stream id.
- msgIn_len  in  6  payload byte count, 0..37.
- msgIn_val  in  1  message valid.
- msgIn_ready  out  1  block can accept a message.
- dropErr  out  1  one-cycle pulse when an accepted message is discarded.
- dataOut  out  32  output word.
- dataOut_val  out  1  output word valid.
- dataOut_ready  in  1  downstream accepts the word.
- dataOut_last  out  1  final word of the packet.

## Operation
- States: IDLE, HDR, SEQ, PAY.
- **IDLE:** msgIn_ready=1. On msgIn_val&&msgIn_ready, latch payload, stream, len and seq = cnt[stream]; then cnt[stream] += 1, wrapping 0xFFFFFFFF→0.
- **Drop:** if stream ≥ NUM_STREAMS or len > 37, the message is accepted, dropped and dropErr pulses. No counter changes. The block stays in IDLE.
- Otherwise go to HDR.
- Wire length L = len+8 bytes. Word count W = ceil(L/4), range 2..12.
- Wire byte order: byte 0 of each word is bits [31:24]; multi-byte fields are little-endian.
- **HDR word:** {L[7:0], L[15:8], stream[7:0], stream[15:8]}. Stream 12, L=20 gives 0x14000C00.
- **SEQ word:** {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}.
- **PAY words:** payload byte k goes to word 2+k/4, bits [31-8(k%4) -: 8]. Unused trailing bytes are 0.
- Each state advances only on dataOut_val&&dataOut_ready.
  - HDR → SEQ.
  - SEQ → PAY, or → IDLE if len==0.
  - PAY uses a word index; → IDLE after word W-1.
- dataOut_last=1 only on word W-1.
- dataOut and dataOut_last are held stable while dataOut_val&&!dataOut_ready.

## Timing
- **Reset values:** state=IDLE, all counters 0, dataOut=0, dataOut_val=0, dataOut_last=0, dropErr=0. msgIn_ready=0 while reset is high; it is 1 in the first cycle after reset falls.
- **Latency:** accept at edge N gives the HDR word valid after edge N. With dataOut_ready held high, one packet takes W cycles.
- msgIn_ready is combinational, state==IDLE && !reset. There is one IDLE cycle between packets, so a new message is accepted no earlier than the cycle after the last-word handshake.
- dataOut_val never drops without a handshake, except on reset.
- **Reset mid-packet:** the packet is aborted. dataOut_val=0 after the reset edge and counters are cleared. No partial packet is ever resumed.
- The counter update and the accept happen on the same edge. Back-to-back messages on the same stream get consecutive seq values.

## Configuration
- PACKETIZER_SEQ_SKIP_EN: when defined, adds input seqSkip (1 bit), sampled with the message handshake.
  - seqSkip=1: the message carries cnt+1 and the counter advances by 2. This injects a one-packet gap so the receiver's packetLost can be exercised.
- When undefined, the port is absent and sequence numbers are always consecutive.

## Structure
- Package packetizer_pkg holds:
  - the state enum;
  - HDR_BYTES=8 and WORD_BYTES=4;
  - MAX_PAYLOAD_BYTES;
  - function num_words(len) returning ceil((len+8)/4);
  - functions le16/le32 for byte-swapping.
- Sub-module seq_table: NUM_STREAMS×32-bit counters with synchronous clear, a read port, and an increment-by-1-or-2 port.

## Test plan
- Stream 12, len 12, payload bytes 0x01..0x0C, dataOut_ready=1.
  - Expect 5 words: 0x14000C00, 0x00000000, 0x01020304, 0x05060708, 0x090A0B0C.
  - dataOut_last on word 5.
- Second stream-12 message, then one on stream 13.
  - Seq words 0x01000000 and 0x00000000.
- Stream 14, len 37.
  - Expect 12 words: header 0x2D000E00; last word has bytes 1..3 = 0.
  - dataOut_ready toggled 0/1 every 3 cycles: words stay held and none are duplicated.
- len 0 on stream 3.
  - Expect 2 words: 0x08000300, then the seq word with last=1.
  - msgIn_ready returns 1 exactly one cycle later.
- Stream 20 (≥16) or len 40.
  - dropErr pulses once, no dataOut_val, and the next valid message keeps the expected seq.
- Reset asserted mid-PAY: dataOut_val=0 on the next cycle; the next stream-12 message has seq 0.
- With PACKETIZER_SEQ_SKIP_EN: seqSkip=1 on stream 5 message 0 gives seq 1; the next message gives seq 2.

Source files
------------

// File: rtl/packetizer_pkg.sv
// packetizer_pkg: shared state enum, framing constants and byte-order helpers for the packetizer
package packetizer_pkg;
  typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_e;
  localparam int NUM_STREAMS = 16;
  localparam int SW = $clog2(NUM_STREAMS);
  localparam int MAX_PAYLOAD_BYTES = 37;
  localparam int HDR_BYTES = 8;
  localparam int WORD_BYTES = 4;
  function automatic logic [3:0] num_words(input logic [5:0] len);
    return 4'(({1'b0, len} + 7'(HDR_BYTES + WORD_BYTES - 1)) / 7'(WORD_BYTES));
  endfunction
  function automatic logic [15:0] le16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction
  function automatic logic [31:0] le32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
endpackage

// File: rtl/packetizer_seq_table.sv
// seq_table: per-stream 32-bit sequence counters with sync clear, read port and +1/+2 increment
module seq_table #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          inc_en,
  input  logic [IW-1:0] inc_idx,
  input  logic          inc_two
);
  logic [31:0] cnt_q [N];
  assign rd_data = cnt_q[rd_idx];
  // counters wrap naturally at 2^32; clear has priority over increment
  always_ff @(posedge clk) begin
    if (clr) for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    else if (inc_en) cnt_q[inc_idx] <= cnt_q[inc_idx] + (inc_two ? 32'd2 : 32'd1);
  end
endmodule

// File: rtl/packetizer.sv
// packetizer: frames a message as header/sequence/payload 32-bit words; optional PACKETIZER_SEQ_SKIP_EN adds seqSkip
module packetizer
  import packetizer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [0:295]  msgIn,
  input  logic [15:0]   msgIn_stream,
  input  logic [5:0]    msgIn_len,
  input  logic          msgIn_val,
  output logic          msgIn_ready,
  output logic          dropErr,
  output logic [31:0]   dataOut,
  output logic          dataOut_val,
  input  logic          dataOut_ready,
`ifdef PACKETIZER_SEQ_SKIP_EN
  input  logic          seqSkip,
`endif
  output logic          dataOut_last
);
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [5:0]  len_q;
  logic [15:0] stream_q;
  logic [31:0] seq_q, cnt_rd, pay_w;
  logic [7:0]  pay_q [MAX_PAYLOAD_BYTES];
  logic        drop_q, skip, acc, bad, hs, last_w;
  logic [5:0]  b0;
`ifdef PACKETIZER_SEQ_SKIP_EN
  assign skip = seqSkip;
`else
  assign skip = 1'b0;
`endif
  assign msgIn_ready = state_q == IDLE && !reset;
  assign acc = msgIn_val && msgIn_ready;
  assign bad = msgIn_stream >= 16'(NUM_STREAMS) || msgIn_len > 6'(MAX_PAYLOAD_BYTES);
  assign hs = dataOut_val && dataOut_ready;
  seq_table #(.N(NUM_STREAMS)) u_seq (
    .clk     (clk),
    .clr     (reset),
    .rd_idx  (msgIn_stream[SW-1:0]),
    .rd_data (cnt_rd),
    .inc_en  (acc && !bad),
    .inc_idx (msgIn_stream[SW-1:0]),
    .inc_two (skip)
  );
  // next state: every non-idle state advances only on an output handshake
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    unique case (state_q)
      IDLE: state_d = acc && !bad ? HDR : IDLE;
      HDR:  state_d = hs ? SEQ : HDR;
      SEQ: begin
        state_d = hs ? (len_q == '0 ? IDLE : PAY) : SEQ;
        idx_d = hs ? 4'd2 : idx_q;
      end
      PAY: begin
        state_d = hs && last_w ? IDLE : PAY;
        idx_d = hs ? idx_q + 4'd1 : idx_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  // message capture on accept; seq is the counter value before this edge's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
      stream_q <= '0;
      seq_q <= '0;
      drop_q <= 1'b0;
      for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) pay_q[k] <= '0;
    end else begin
      drop_q <= acc && bad;
      if (acc) begin
        len_q <= msgIn_len;
        stream_q <= msgIn_stream;
        seq_q <= cnt_rd + 32'(skip);
        for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) pay_q[k] <= msgIn[8*k +: 8];
      end
    end
  end
  // output word mux; payload bytes at or beyond len are forced to zero
  always_comb begin
    pay_w = '0;
    b0 = {idx_q - 4'd2, 2'b00};
    for (int j = 0; j < 4; j++) pay_w[31-8*j -: 8] = b0 + 6'(j) < len_q ? pay_q[b0 + 6'(j)] : 8'h00;
    last_w = (state_q == PAY && idx_q == num_words(len_q) - 4'd1) || (state_q == SEQ && len_q == '0);
    dataOut = state_q == HDR ? {le16(16'(len_q) + 16'(HDR_BYTES)), le16(stream_q)} :
              state_q == SEQ ? le32(seq_q) :
              state_q == PAY ? pay_w : '0;
    dataOut_val = state_q != IDLE;
    dataOut_last = last_w;
    dropErr = drop_q;
  end
endmodule

// File: tb/tb_packetizer.sv
// tb_packetizer: randomized self-checking bench with a byte-level framing model
module tb_packetizer;
  logic clk = 0;
  logic reset;
  logic [0:295] msgIn;
  logic [15:0] msgIn_stream;
  logic [5:0] msgIn_len;
  logic msgIn_val, msgIn_ready, dropErr;
  logic [31:0] dataOut;
  logic dataOut_val, dataOut_ready, dataOut_last;
`ifdef PACKETIZER_SEQ_SKIP_EN
  logic seqSkip = 1'b0;
`endif
  int total = 0, bad = 0;
  int unsigned cnt_m [16];
  logic [7:0] pb [37];
  logic [31:0] exp_w [$];
  logic [31:0] got_w [$];
  bit got_l [$];
  int hold_err;
  bit tmo;

  packetizer dut (
    .clk(clk), .reset(reset), .msgIn(msgIn), .msgIn_stream(msgIn_stream), .msgIn_len(msgIn_len),
    .msgIn_val(msgIn_val), .msgIn_ready(msgIn_ready), .dropErr(dropErr), .dataOut(dataOut),
    .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
`ifdef PACKETIZER_SEQ_SKIP_EN
    .seqSkip(seqSkip),
`endif
    .dataOut_last(dataOut_last)
  );

  always #5 clk = ~clk;

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) cnt_m[i] = 0;
  endfunction

  function automatic void fill_rand();
    for (int k = 0; k < 37; k++) pb[k] = 8'($urandom);
  endfunction

  function automatic void model(input logic [15:0] s, input int len, input bit skip);
    logic [7:0] wb [$];
    logic [31:0] sq;
    logic [15:0] l16;
    l16 = 16'(len + 8);
    sq = cnt_m[s[3:0]] + 32'(skip);
    cnt_m[s[3:0]] = cnt_m[s[3:0]] + 1 + 32'(skip);
    wb = {l16[7:0], l16[15:8], s[7:0], s[15:8], sq[7:0], sq[15:8], sq[23:16], sq[31:24]};
    for (int k = 0; k < len; k++) wb.push_back(pb[k]);
    while (wb.size() % 4 != 0) wb.push_back(8'h00);
    exp_w.delete();
    for (int i = 0; i < wb.size(); i += 4) exp_w.push_back({wb[i], wb[i+1], wb[i+2], wb[i+3]});
  endfunction

  task automatic send(input logic [15:0] s, input logic [5:0] len, input bit skip);
    int w = 0;
    while (!msgIn_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!msgIn_ready) begin total++; bad++; $display("FAIL send_ready got=0 want=1"); end
    for (int k = 0; k < 37; k++) msgIn[8*k +: 8] = pb[k];
    msgIn_stream = s;
    msgIn_len = len;
`ifdef PACKETIZER_SEQ_SKIP_EN
    seqSkip = skip;
`endif
    msgIn_val = 1;
    @(posedge clk); #1;
    msgIn_val = 0;
  endtask

  task automatic collect(input int mode);
    logic [31:0] pw = '0;
    bit pl = 0, pstall = 0;
    got_w.delete(); got_l.delete(); hold_err = 0; tmo = 0;
    for (int c = 0; c < 400; c++) begin
      dataOut_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'((c / 3) % 2) : 1'($urandom % 2);
      #0;
      if (pstall && (!dataOut_val || dataOut !== pw || dataOut_last !== pl)) hold_err++;
      pstall = dataOut_val && !dataOut_ready;
      pw = dataOut;
      pl = dataOut_last;
      if (dataOut_val && dataOut_ready) begin
        got_w.push_back(dataOut);
        got_l.push_back(dataOut_last);
        if (dataOut_last) begin @(posedge clk); #1; dataOut_ready = 1; return; end
      end
      @(posedge clk); #1;
    end
    tmo = 1;
    dataOut_ready = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dataOut_val !== 0) begin bad++; $display("FAIL rst_val got=%b want=0", dataOut_val); end
    total++; if (dataOut !== 0) begin bad++; $display("FAIL rst_data got=%h want=0", dataOut); end
    total++; if (dataOut_last !== 0 || dropErr !== 0) begin bad++; $display("FAIL rst_last_drop got=%b%b want=00", dataOut_last, dropErr); end
    total++; if (msgIn_ready !== 0) begin bad++; $display("FAIL rst_ready_hi got=%b want=0", msgIn_ready); end
    reset = 0;
    #1;
    total++; if (msgIn_ready !== 1) begin bad++; $display("FAIL rst_ready_lo got=%b want=1", msgIn_ready); end
    clear_model();
  endtask

  task automatic test_basic();
    logic [31:0] ref_w [5] = '{32'h14000C00, 32'h00000000, 32'h01020304, 32'h05060708, 32'h090A0B0C};
    fill_rand();
    for (int k = 0; k < 12; k++) pb[k] = 8'(k + 1);
    model(12, 12, 0);
    send(12, 12, 0);
    total++; if (dataOut_val !== 1 || dataOut !== 32'h14000C00) begin bad++; $display("FAIL basic_latency got=%b/%h want=1/14000c00", dataOut_val, dataOut); end
    collect(0);
    total++; if (got_w.size() != 5 || tmo) begin bad++; $display("FAIL basic_count got=%0d want=5", got_w.size()); end
    for (int i = 0; i < 5 && i < got_w.size(); i++) begin
      total++;
      if (got_w[i] !== ref_w[i] || got_w[i] !== exp_w[i] || got_l[i] !== (i == 4)) begin
        bad++; $display("FAIL basic_word%0d got=%h/%b want=%h/%b", i, got_w[i], got_l[i], ref_w[i], i == 4);
      end
    end
  endtask

  task automatic test_seq();
    logic [31:0] want_seq [2] = '{32'h01000000, 32'h00000000};
    for (int m = 0; m < 2; m++) begin
      fill_rand();
      model(16'(12 + m), 4, 0);
      send(16'(12 + m), 4, 0);
      collect(0);
      total++; if (got_w.size() != exp_w.size() || tmo) begin bad++; $display("FAIL seq%0d_count got=%0d want=%0d", m, got_w.size(), exp_w.size()); end
      total++; if (got_w.size() < 2 || got_w[1] !== want_seq[m]) begin bad++; $display("FAIL seq%0d_word got=%h want=%h", m, got_w.size() > 1 ? got_w[1] : 32'hx, want_seq[m]); end
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL seq%0d_w%0d got=%h want=%h", m, i, got_w[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_long_backpressure();
    fill_rand();
    model(14, 37, 0);
    send(14, 37, 0);
    collect(1);
    total++; if (got_w.size() != 12 || tmo) begin bad++; $display("FAIL long_count got=%0d want=12", got_w.size()); end
    total++; if (got_w.size() < 1 || got_w[0] !== 32'h2D000E00) begin bad++; $display("FAIL long_hdr got=%h want=2d000e00", got_w.size() > 0 ? got_w[0] : 32'hx); end
    total++; if (got_w.size() != 12 || got_w[11][23:0] !== 24'h0) begin bad++; $display("FAIL long_tail got=%h want=%h", got_w.size() == 12 ? got_w[11] : 32'hx, {pb[36], 24'h0}); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL long_hold got=%0d want=0", hold_err); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        bad++; $display("FAIL long_w%0d got=%h/%b want=%h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
  endtask

  task automatic test_zero_len();
    fill_rand();
    model(3, 0, 0);
    send(3, 0, 0);
    total++; if (msgIn_ready !== 0) begin bad++; $display("FAIL zero_busy got=%b want=0", msgIn_ready); end
    collect(0);
    total++; if (got_w.size() != 2 || tmo) begin bad++; $display("FAIL zero_count got=%0d want=2", got_w.size()); end
    total++; if (got_w.size() < 1 || got_w[0] !== 32'h08000300) begin bad++; $display("FAIL zero_hdr got=%h want=08000300", got_w.size() > 0 ? got_w[0] : 32'hx); end
    total++; if (got_w.size() != 2 || got_w[1] !== exp_w[1] || got_l[1] !== 1 || got_l[0] !== 0) begin bad++; $display("FAIL zero_seq got=%h want=%h/last", got_w.size() == 2 ? got_w[1] : 32'hx, exp_w[1]); end
    total++; if (msgIn_ready !== 1) begin bad++; $display("FAIL zero_ready got=%b want=1", msgIn_ready); end
  endtask

  task automatic test_drop();
    logic [15:0] ds [2] = '{16'd20, 16'd12};
    logic [5:0] dl [2] = '{6'd5, 6'd40};
    for (int m = 0; m < 2; m++) begin
      int p = 0;
      bit v = 0;
      fill_rand();
      send(ds[m], dl[m], 0);
      for (int c = 0; c < 5; c++) begin p += int'(dropErr); v |= dataOut_val; @(posedge clk); #1; end
      total++; if (p != 1 || v) begin bad++; $display("FAIL drop%0d got=pulses %0d val %b want=pulses 1 val 0", m, p, v); end
    end
    fill_rand();
    model(12, 4, 0);
    send(12, 4, 0);
    collect(0);
    total++; if (got_w.size() != exp_w.size() || tmo) begin bad++; $display("FAIL drop_next_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL drop_next_w%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    fill_rand();
    send(12, 20, 0);
    dataOut_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dataOut_val !== 1) begin bad++; $display("FAIL mid_inpay got=%b want=1", dataOut_val); end
    reset = 1;
    @(posedge clk); #1;
    total++; if (dataOut_val !== 0) begin bad++; $display("FAIL mid_abort got=%b want=0", dataOut_val); end
    reset = 0;
    #1;
    clear_model();
    fill_rand();
    model(12, 3, 0);
    send(12, 3, 0);
    collect(0);
    total++; if (got_w.size() != exp_w.size() || tmo) begin bad++; $display("FAIL mid_count got=%0d want=%0d", got_w.size(), exp_w.size()); end
    total++; if (got_w.size() < 2 || got_w[1] !== 32'h0) begin bad++; $display("FAIL mid_seq got=%h want=00000000", got_w.size() > 1 ? got_w[1] : 32'hx); end
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      total++; if (got_w[i] !== exp_w[i]) begin bad++; $display("FAIL mid_w%0d got=%h want=%h", i, got_w[i], exp_w[i]); end
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 30; m++) begin
      logic [15:0] s;
      logic [5:0] len;
      s = ($urandom % 8 == 0) ? 16'(16 + $urandom % 1000) : 16'($urandom % 16);
      len = ($urandom % 8 == 0) ? 6'(38 + $urandom % 26) : 6'($urandom % 38);
      fill_rand();
      if (s >= 16 || len > 37) begin
        send(s, len, 0);
        total++; if (dropErr !== 1 || dataOut_val !== 0) begin bad++; $display("FAIL rnd%0d_drop got=%b/%b want=1/0", m, dropErr, dataOut_val); end
      end else begin
        model(s, int'(len), 0);
        send(s, len, 0);
        collect(2);
        total++; if (got_w.size() != exp_w.size() || tmo || hold_err != 0) begin bad++; $display("FAIL rnd%0d_count got=%0d hold=%0d want=%0d hold=0", m, got_w.size(), hold_err, exp_w.size()); end
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
          total++;
          if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
            bad++; $display("FAIL rnd%0d_w%0d got=%h/%b want=%h/%b", m, i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
          end
        end
      end
    end
  endtask

`ifdef PACKETIZER_SEQ_SKIP_EN
  task automatic test_skip();
    logic [31:0] want_seq [2] = '{32'h01000000, 32'h02000000};
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #1;
    clear_model();
    for (int m = 0; m < 2; m++) begin
      fill_rand();
      model(5, 2, m == 0);
      send(5, 2, m == 0);
      seqSkip = 0;
      collect(0);
      total++; if (got_w.size() != 2 || got_w[1] !== want_seq[m] || got_w[1] !== exp_w[1]) begin bad++; $display("FAIL skip%0d got=%h want=%h", m, got_w.size() > 1 ? got_w[1] : 32'hx, want_seq[m]); end
    end
  endtask
`endif

  initial begin
    msgIn = '0; msgIn_stream = '0; msgIn_len = '0; msgIn_val = 0; dataOut_ready = 1; reset = 1;
    test_reset();
    test_basic();
    test_seq();
    test_long_backpressure();
    test_zero_len();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef PACKETIZER_SEQ_SKIP_EN
    test_skip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
